// File: rtl/sig_dump_pkg.sv
// Shared types and constants for the compliance signature dump unit.
package sig_dump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [30:0] STALL_CODE      = 31'h7FFF_FFFF;

  function automatic logic code_is_pass(input logic [30:0] code);
    return (code == 31'd0);
  endfunction

endpackage

// File: rtl/halt_detect.sv
// Halt detection: TOHOST mailbox snoop, plus a PC-stall detector when
// HALT_LOOP_DETECT_EN is defined. Emits a single-cycle halt request with its code.
module halt_detect
  import sig_dump_pkg::*;
#(
  parameter int          DATA_W       = 32,
  parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF,
  parameter int          STALL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              dmem_we,
  input  logic [31:0]       dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [31:0]       pc,
  output logic              halt,
  output logic [30:0]       halt_code,
  output logic              halt_pass
);

  logic tohost_hit_s;
  assign tohost_hit_s = arm && dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];

`ifdef HALT_LOOP_DETECT_EN
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [31:0]      pc_prev_q, pc_prev_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_hit_s;

  // Saturating count of consecutive cycles with an unchanged PC.
  always_comb begin
    pc_prev_d = pc;
    if (pc != pc_prev_q) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    stall_hit_s = arm && (stall_cnt_q == STALL_MAX);
    halt        = tohost_hit_s || stall_hit_s;
    // The mailbox wins when both fire in the same cycle.
    if (tohost_hit_s) begin
      halt_code = dmem_wdata[31:1];
      halt_pass = code_is_pass(dmem_wdata[31:1]);
    end else begin
      halt_code = STALL_CODE;
      halt_pass = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_prev_q   <= 32'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pc_prev_q   <= pc_prev_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  logic pc_unused_s;
  assign pc_unused_s = ^{clk, rst_n, pc};
  assign halt        = tohost_hit_s;
  assign halt_code   = dmem_wdata[31:1];
  assign halt_pass   = code_is_pass(dmem_wdata[31:1]);
`endif

endmodule

// File: rtl/sig_dump_unit.sv
// Signature dump: waits for a halt, then reads the DMEM signature window and
// streams it over valid/ready. Optional stall halt: HALT_LOOP_DETECT_EN.
module sig_dump_unit
  import sig_dump_pkg::*;
#(
  parameter int          DATA_W        = 32,
  parameter int          ADDR_W        = 8,
  parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
  parameter int          SIG_BASE_WORD = 192,
  parameter int          SIG_END_WORD  = 256,
  parameter int          STALL_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_we,
  input  logic [31:0]       dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [31:0]       pc,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [DATA_W-1:0] sig_data,
  output logic              sig_last,
  output logic              halted,
  output logic              pass,
  output logic [30:0]       test_code,
  output logic              done
);

  // One extra index bit so a window ending at 2**ADDR_W does not wrap.
  localparam int               IDX_W     = ADDR_W + 1;
  localparam logic [IDX_W-1:0] BASE_IDX  = IDX_W'(SIG_BASE_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SIG_END_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam bit               EMPTY_WIN = (SIG_BASE_WORD == SIG_END_WORD);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc_s;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              sig_valid_q, sig_valid_d;
  logic [DATA_W-1:0] sig_data_q, sig_data_d;
  logic              sig_last_q, sig_last_d;
  logic              halted_q, halted_d;
  logic              pass_q, pass_d;
  logic [30:0]       test_code_q, test_code_d;
  logic              done_q, done_d;
  logic              arm_s, halt_s, halt_pass_s;
  logic [30:0]       halt_code_s;

  assign arm_s = (state_q == IDLE);

  halt_detect #(
    .DATA_W      (DATA_W),
    .TOHOST_ADDR (TOHOST_ADDR),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_halt_detect (
    .clk       (clk),
    .rst_n     (reset),
    .arm       (arm_s),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .pc        (pc),
    .halt      (halt_s),
    .halt_code (halt_code_s),
    .halt_pass (halt_pass_s)
  );

  // Next-state and next-output logic; outputs are registered one step ahead of the state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idx_inc_s   = idx_q + IDX_ONE;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    sig_valid_d = sig_valid_q;
    sig_data_d  = sig_data_q;
    sig_last_d  = sig_last_q;
    halted_d    = halted_q;
    pass_d      = pass_q;
    test_code_d = test_code_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (halt_s) begin
          halted_d    = 1'b1;
          pass_d      = halt_pass_s;
          test_code_d = halt_code_s;
          if (EMPTY_WIN) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q[ADDR_W-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        sig_data_d  = rd_data;
        sig_last_d  = (idx_q == LAST_IDX);
        sig_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (sig_ready) begin
          sig_valid_d = 1'b0;
          if (sig_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_inc_s;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_inc_s[ADDR_W-1:0];
            state_d   = FETCH;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        sig_valid_d = 1'b0;
        done_d      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= BASE_IDX;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {ADDR_W{1'b0}};
      sig_valid_q <= 1'b0;
      sig_data_q  <= {DATA_W{1'b0}};
      sig_last_q  <= 1'b0;
      halted_q    <= 1'b0;
      pass_q      <= 1'b0;
      test_code_q <= 31'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      sig_valid_q <= sig_valid_d;
      sig_data_q  <= sig_data_d;
      sig_last_q  <= sig_last_d;
      halted_q    <= halted_d;
      pass_q      <= pass_d;
      test_code_q <= test_code_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign sig_valid = sig_valid_q;
  assign sig_data  = sig_data_q;
  assign sig_last  = sig_last_q;
  assign halted    = halted_q;
  assign pass      = pass_q;
  assign test_code = test_code_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sig_dump_unit.sv
// Self-checking bench for sig_dump_unit: table of mailbox stores, random store
// streams against a simple halt/stream model, and hand-written stall/abort sequences.
module tb_sig_dump_unit;

  localparam int BASE   = 192;
  localparam int NWORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data = 32'd0;
  logic        sig_valid;
  logic        sig_ready = 1'b0;
  logic [31:0] sig_data;
  logic        sig_last;
  logic        halted;
  logic        pass;
  logic [30:0] test_code;
  logic        done;

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;
  bit pc_freeze = 1'b0;
  logic [31:0] mem [0:255];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_halt;
    logic        exp_pass;
    logic [30:0] exp_code;
    int          ready_mode;
  } vec_t;

  vec_t vecs [7];

  sig_dump_unit dut (
    .clk       (clk),
    .reset     (reset),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .pc        (pc),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sig_valid (sig_valid),
    .sig_ready (sig_ready),
    .sig_data  (sig_data),
    .sig_last  (sig_last),
    .halted    (halted),
    .pass      (pass),
    .test_code (test_code),
    .done      (done)
  );

  always #5 clk = ~clk;

  // DMEM read port: data one cycle after the enable.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!pc_freeze) pc = pc + 32'd4;
    if (rd_en) rd_seen++;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dmem_we = 1'b0;
    sig_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    rd_seen = 0;
    tick();
  endtask

  task automatic store(input logic we, input logic [31:0] addr, input logic [31:0] data);
    dmem_we = we;
    dmem_addr = addr;
    dmem_wdata = data;
    tick();
    dmem_we = 1'b0;
  endtask

  // Consume the stream; mode 0: ready high, 1: random ready.
  task automatic run_dump(input int mode, input int stall_word, input int abort_word);
    int k = 0;
    int cyc = 0;
    int last_hs = -1;
    int held = 0;
    bit prev_wait = 1'b0;
    bit aborted = 1'b0;
    bit rdy;
    logic [31:0] prev_data = 32'd0;
    while (!aborted && k < NWORDS && cyc < 2000) begin
      if (rd_en) check("rd_addr", rd_addr, BASE + k);
      if (prev_wait) begin
        check("hold_valid", sig_valid, 1);
        check("hold_data", sig_data, prev_data);
      end
      if (sig_valid && abort_word == BASE + k) begin
        #2 reset = 1'b0;
        #1 check("abort_outs", {rd_en, rd_addr, sig_valid, sig_data, sig_last,
                                halted, pass, test_code, done}, 0);
        sig_ready = 1'b0;
        aborted = 1'b1;
      end else begin
        if (sig_valid) begin
          if (stall_word == BASE + k && held < 5) begin
            rdy = 1'b0;
            held++;
          end else if (mode == 1) begin
            rdy = 1'($urandom_range(0, 1));
          end else begin
            rdy = 1'b1;
          end
          sig_ready = rdy;
          if (rdy) begin
            check("word_data", sig_data, mem[BASE + k]);
            check("word_last", sig_last, (k == NWORDS - 1));
            if (mode == 0 && stall_word < 0 && last_hs >= 0) check("interval", cyc - last_hs, 3);
            last_hs = cyc;
            k++;
            prev_wait = 1'b0;
          end else begin
            prev_wait = 1'b1;
            prev_data = sig_data;
          end
        end else begin
          sig_ready = 1'($urandom_range(0, 1));
          prev_wait = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    sig_ready = 1'b0;
    if (!aborted) begin
      check("dump_timeout", (cyc >= 2000), 0);
      check("word_count", k, NWORDS);
      check("done", done, 1);
      check("valid_after_done", sig_valid, 0);
      repeat (5) tick();
      check("done_sticky", {done, sig_valid, rd_en}, 3'b100);
      check("rd_count", rd_seen, NWORDS);
    end
  endtask

  initial begin
    int got;
    bit hit;
    logic [31:0] a;
    logic [31:0] d;
    logic w;
    logic [30:0] ecode;

    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    logic [31:0] a;
    logic [31:0] d;
    logic w;
    logic [30:0] ecode;
    bit eq;

    vecs[0] = '{1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1, 31'd0,          0};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'h0000_0007, 1'b1, 1'b0, 31'd3,          1};
    vecs[2] = '{1'b1, 32'h0000_1000, 32'h0000_0006, 1'b0, 1'b0, 31'd0,          0};
    vecs[3] = '{1'b1, 32'h0000_1004, 32'h0000_0001, 1'b0, 1'b0, 31'd0,          0};
    vecs[4] = '{1'b0, 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0, 31'd0,          0};
    vecs[5] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 1'b0, 31'h7FFF_FFFF, 1};
    vecs[6] = '{1'b1, 32'h0000_1001, 32'h0000_0001, 1'b0, 1'b0, 31'd0,          0};

    // Reset values while reset is held.
    reset = 1'b0;
    tick();
    check("reset_outs", {rd_en, rd_addr, sig_valid, sig_data, sig_last,
                         halted, pass, test_code, done}, 0);

    // Table-driven mailbox stores.
    for (int i = 0; i < 7; i++) begin
      fill_mem();
      do_reset();
      store(vecs[i].we, vecs[i].addr, vecs[i].data);
      check("halted", halted, vecs[i].exp_halt);
      if (vecs[i].exp_halt) begin
        check("pass", pass, vecs[i].exp_pass);
        check("test_code", test_code, vecs[i].exp_code);
        check("first_fetch", {rd_en, rd_addr}, {1'b1, 8'(BASE)});
        check("lat_valid0", sig_valid, 0);
        tick();
        check("lat_valid1", sig_valid, 0);
        tick();
        check("lat_valid2", sig_valid, 1);
        run_dump(vecs[i].ready_mode, -1, -1);
      end else begin
        repeat (20) tick();
        check("no_halt", {halted, done, sig_valid}, 3'b000);
        check("no_read", rd_seen, 0);
      end
    end

    // A later mailbox store after the halt is ignored.
    fill_mem();
    do_reset();
    store(1'b1, 32'h0000_1000, 32'h0000_0007);
    store(1'b1, 32'h0000_1000, 32'h0000_0001);
    check("first_wins", {halted, pass, test_code}, {1'b1, 1'b0, 31'd3});
    run_dump(1, -1, -1);

    // Random store streams against the halt model.
    for (int it = 0; it < 4; it++) begin
      fill_mem();
      do_reset();
      hit = 1'b0;
      ecode = 31'd0;
      for (int s = 0; s < 12 && !hit; s++) begin
        w = 1'($urandom_range(0, 1));
        a = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h0000_1000 + 32'($urandom_range(1, 3) * 4);
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = d & 32'h0000_0001;
        if (s == 11) begin
          w = 1'b1;
          a = 32'h0000_1000;
          d = d | 32'h0000_0001;
        end
        store(w, a, d);
        if (w && a == 32'h0000_1000 && d[0]) begin
          hit = 1'b1;
          ecode = d[31:1];
        end
        check("rand_halted", halted, hit);
      end
      check("rand_code", test_code, ecode);
      check("rand_pass", pass, (ecode == 31'd0));
      run_dump(1, -1, -1);
    end

    // Back-pressure on word 200.
    fill_mem();
    do_reset();
    store(1'b1, 32'h0000_1000, 32'h0000_0001);
    run_dump(0, 200, -1);

    // Reset during word 210, then a fresh dump from the start.
    fill_mem();
    do_reset();
    store(1'b1, 32'h0000_1000, 32'h0000_0001);
    run_dump(1, -1, 210);
    tick();
    reset = 1'b1;
    rd_seen = 0;
    tick();
    check("post_abort_idle", {halted, done, sig_valid, rd_en}, 4'b0000);
    store(1'b1, 32'h0000_1000, 32'h0000_0001);
    check("restart_fetch", {rd_en, rd_addr}, {1'b1, 8'(BASE)});
    run_dump(0, -1, -1);

    // PC frozen: halt only with the stall detector built in.
    do_reset();
    pc = 32'h0000_0040;
    pc_freeze = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      tick();
      hit = halted;
    end
`ifdef HALT_LOOP_DETECT_EN
    check("stall_halt", hit, 1);
    check("stall_code", {pass, test_code}, {1'b0, 31'h7FFF_FFFF});
`else
    check("stall_no_halt", hit, 0);
    check("stall_no_read", rd_seen, 0);
`endif
    pc_freeze = 1'b0;
    eq = (checks > 0);
    if (!eq) $display("no checks were made");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
